// File: rtl/ifs_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding and default geometry.
package ifs_pkg;

  localparam int ADDR_W_DEF    = 4;
  localparam int DATA_W_DEF    = 16;
  localparam int LAST_ADDR_DEF = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4
  } ifs_state_e;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bundle between the fetch sequencer, the instruction ROM and the SCU.
// Handshake: run is a one-cycle strobe meaning instr is valid and may be executed;
// instr stays stable until the SCU answers with a rising edge on done, which acts as the ready/ack.
interface instr_fetch_seq_if
  import ifs_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic              run;
  logic              done;
  logic              busy;
  logic              prog_done;
  ifs_state_e        state;

  modport master (
    input  start, abort, rom_data, done,
    output rom_addr, instr, run, busy, prog_done, state
  );

  modport slave (
    output start, abort, rom_data, done,
    input  rom_addr, instr, run, busy, prog_done, state
  );
endinterface

// File: rtl/sync_edge_det.sv
// Rising-edge detector for the SCU done level; with IFS_DONE_SYNC_EN defined a two-flop
// synchronizer sits in front of it so done may come from the Pclk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_s;
  logic d_q;

`ifdef IFS_DONE_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], d};
    end
  end

  assign d_s = sync[1];
`else
  assign d_s = d;
`endif

  // History register runs continuously, so a level already high on entry never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_s;
    end
  end

  assign rise = d_s & ~d_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks pc through the ROM, issues each word to the SCU with a
// run pulse and waits for done. Optional macro IFS_DONE_SYNC_EN adds a done synchronizer.
module instr_fetch_seq
  import ifs_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LAST_ADDR = LAST_ADDR_DEF
) (
  input  logic                Mclk,
  input  logic                Resetn,
  instr_fetch_seq_if.master   ifs
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  ifs_state_e        state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] instr, instr_n;
  logic              run, run_n;
  logic              prog_done, prog_done_n;
  logic              done_rise;

  sync_edge_det u_done_det (
    .clk   (Mclk),
    .rst_n (Resetn),
    .d     (ifs.done),
    .rise  (done_rise)
  );

  always_ff @(posedge Mclk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= '0;
      run       <= 1'b0;
      prog_done <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr     <= instr_n;
      run       <= run_n;
      prog_done <= prog_done_n;
    end
  end

  // run and prog_done are strobes: they default low and are raised only on the one transition.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_n     = instr;
    run_n       = 1'b0;
    prog_done_n = 1'b0;

    if (ifs.abort) begin
      state_n = IDLE;
      pc_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          pc_n = '0;
          if (ifs.start) begin
            state_n = FETCH;
          end
        end
        FETCH: begin
          state_n = LOAD;
        end
        LOAD: begin
          instr_n = ifs.rom_data;
          run_n   = 1'b1;
          state_n = WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            state_n = NEXT;
          end
        end
        NEXT: begin
          if (pc == LAST_PC) begin
            pc_n        = '0;
            prog_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = FETCH;
          end
        end
        default: begin
          state_n = IDLE;
          pc_n    = '0;
        end
      endcase
    end
  end

  assign ifs.rom_addr  = pc;
  assign ifs.instr     = instr;
  assign ifs.run       = run;
  assign ifs.prog_done = prog_done;
  assign ifs.busy      = (state != IDLE);
  assign ifs.state     = state;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: reset, single fetch, full program, stale done, abort, async reset.
module tb_instr_fetch_seq;
  import ifs_pkg::*;

`ifdef IFS_DONE_SYNC_EN
  localparam int DONE_LAT = 3;
`else
  localparam int DONE_LAT = 1;
`endif

  logic Mclk   = 1'b0;
  logic Resetn = 1'b0;

  instr_fetch_seq_if ifs ();

  instr_fetch_seq #(
    .ADDR_W    (ADDR_W_DEF),
    .DATA_W    (DATA_W_DEF),
    .LAST_ADDR (LAST_ADDR_DEF)
  ) dut (
    .Mclk   (Mclk),
    .Resetn (Resetn),
    .ifs    (ifs)
  );

  // ---------------- clock / reset ----------------
  always #5 Mclk = ~Mclk;

  // ---------------- ROM model and monitors ----------------
  logic [15:0] rom [16];
  logic [15:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int prog_done_cnt = 0;

  always @(posedge Mclk) ifs.rom_data <= rom[ifs.rom_addr];

  always @(posedge Mclk) begin
    #1;
    if (ifs.prog_done === 1'b1) prog_done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Mclk);
    #1;
  endtask

  task automatic start_prog();
    ifs.start = 1'b1;
    tick();
    ifs.start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      tick();
      n++;
      if (ifs.run === 1'b1) ok = 1'b1;
    end
    if (!ok) check("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic done_handshake();
    int n;
    ifs.done = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (ifs.state != NEXT && n < 12);
    check("done_to_next", 32'(n), 32'(DONE_LAT));
    ifs.done = 1'b0;
  endtask

  task automatic do_instr();
    bit ok;
    logic [15:0] exp;
    wait_run(ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
      exp = 16'h0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("instr", 32'(ifs.instr), 32'(exp));
    check("busy_run", 32'(ifs.busy), 32'd1);
    tick();
    check("run_one_cycle", 32'(ifs.run), 32'd0);
    repeat (3) tick();
    done_handshake();
  endtask

  task automatic abort_clean();
    ifs.abort = 1'b1;
    tick();
    ifs.abort = 1'b0;
    check("abort_idle", 32'(ifs.state), 32'(IDLE));
    repeat (4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int pd0;

    ifs.start = 1'b0;
    ifs.abort = 1'b0;
    ifs.done  = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'hA5C3;

    // Reset values, then idle with start low
    repeat (2) tick();
    check("rst_state", 32'(ifs.state), 32'(IDLE));
    check("rst_addr", 32'(ifs.rom_addr), 32'd0);
    check("rst_instr", 32'(ifs.instr), 32'd0);
    check("rst_run", 32'(ifs.run), 32'd0);
    check("rst_busy", 32'(ifs.busy), 32'd0);
    check("rst_prog_done", 32'(ifs.prog_done), 32'd0);
    Resetn = 1'b1;
    repeat (3) tick();
    check("idle_state", 32'(ifs.state), 32'(IDLE));
    check("idle_busy", 32'(ifs.busy), 32'd0);

    // Single fetch: run exactly two edges after start is sampled
    start_prog();
    check("f_state_k", 32'(ifs.state), 32'(FETCH));
    check("f_addr_k", 32'(ifs.rom_addr), 32'd0);
    check("f_busy_k", 32'(ifs.busy), 32'd1);
    check("f_run_k", 32'(ifs.run), 32'd0);
    tick();
    check("f_state_k1", 32'(ifs.state), 32'(LOAD));
    check("f_run_k1", 32'(ifs.run), 32'd0);
    tick();
    check("f_run_k2", 32'(ifs.run), 32'd1);
    check("f_instr_k2", 32'(ifs.instr), 32'hA5C3);
    tick();
    check("f_run_k3", 32'(ifs.run), 32'd0);
    check("f_state_k3", 32'(ifs.state), 32'(WAIT));
    repeat (3) tick();
    check("f_hold_instr", 32'(ifs.instr), 32'hA5C3);
    check("f_hold_state", 32'(ifs.state), 32'(WAIT));
    done_handshake();
    abort_clean();

    // Full program with wrap to idle
    rom[0] = 16'h1000;
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h1000 + 16'(i));
    pd0 = prog_done_cnt;
    start_prog();
    for (int i = 0; i < 16; i++) do_instr();
    tick();
    check("prog_done_pulse", 32'(ifs.prog_done), 32'd1);
    check("prog_end_state", 32'(ifs.state), 32'(IDLE));
    check("prog_end_busy", 32'(ifs.busy), 32'd0);
    check("prog_end_pc", 32'(ifs.rom_addr), 32'd0);
    tick();
    check("prog_done_width", 32'(ifs.prog_done), 32'd0);
    check("prog_done_count", 32'(prog_done_cnt - pd0), 32'd1);
    repeat (4) tick();

    // Stale done: already high before run, needs a fresh rising edge
    ifs.done = 1'b1;
    repeat (4) tick();
    start_prog();
    wait_run(ok);
    check("stale_instr", 32'(ifs.instr), 32'h1000);
    repeat (6) tick();
    check("stale_hold", 32'(ifs.state), 32'(WAIT));
    ifs.done = 1'b0;
    repeat (4) tick();
    check("stale_low_hold", 32'(ifs.state), 32'(WAIT));
    check("stale_pc", 32'(ifs.rom_addr), 32'd0);
    done_handshake();
    abort_clean();

    // Abort in WAIT at pc=6, together with a done edge
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h1000 + 16'(i));
    pd0 = prog_done_cnt;
    start_prog();
    for (int i = 0; i < 6; i++) do_instr();
    wait_run(ok);
    tick();
    check("ab_pc6", 32'(ifs.rom_addr), 32'd6);
    ifs.done  = 1'b1;
    ifs.abort = 1'b1;
    tick();
    ifs.abort = 1'b0;
    ifs.done  = 1'b0;
    check("ab_state", 32'(ifs.state), 32'(IDLE));
    check("ab_pc", 32'(ifs.rom_addr), 32'd0);
    check("ab_run", 32'(ifs.run), 32'd0);
    check("ab_instr_kept", 32'(ifs.instr), 32'h1006);
    repeat (4) tick();
    check("ab_stay_idle", 32'(ifs.state), 32'(IDLE));
    check("ab_no_prog_done", 32'(prog_done_cnt - pd0), 32'd0);

    // abort beats start in IDLE
    ifs.start = 1'b1;
    ifs.abort = 1'b1;
    tick();
    ifs.start = 1'b0;
    ifs.abort = 1'b0;
    check("ab_start_idle", 32'(ifs.state), 32'(IDLE));
    check("ab_start_busy", 32'(ifs.busy), 32'd0);
    repeat (4) tick();

    // Asynchronous reset mid-WAIT at pc=9
    for (int i = 0; i < 9; i++) exp_q.push_back(16'h1000 + 16'(i));
    start_prog();
    for (int i = 0; i < 9; i++) do_instr();
    wait_run(ok);
    check("rs_instr9", 32'(ifs.instr), 32'h1009);
    repeat (2) tick();
    #3;
    Resetn = 1'b0;
    #1;
    check("rs_state", 32'(ifs.state), 32'(IDLE));
    check("rs_addr", 32'(ifs.rom_addr), 32'd0);
    check("rs_instr", 32'(ifs.instr), 32'd0);
    check("rs_run", 32'(ifs.run), 32'd0);
    check("rs_busy", 32'(ifs.busy), 32'd0);
    tick();
    Resetn = 1'b1;
    tick();
    start_prog();
    check("rs_refetch_addr", 32'(ifs.rom_addr), 32'd0);
    exp_q.push_back(16'h1000);
    do_instr();
    abort_clean();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
Instruction fetch sequencer directly upstream of the simple control unit (SCU). Walks a program counter through the synchronous instruction ROM, latches each 16-bit instruction word, issues it to the SCU with a one-cycle run pulse, then waits for the SCU's done before advancing. Runs on Mclk; the SCU runs on Pclk, so done crosses clock domains.

Parameters:
ADDR_W, 4, ROM address / program-counter width
DATA_W, 16, instruction word width
LAST_ADDR, 15, address of the final instruction; after it executes the sequencer returns to idle

Ports:
Mclk  input  1  fetch clock; all state updates on its rising edge
Resetn  input  1  asynchronous, active-low reset
start  input  1  level; sampled in IDLE, begins program execution at pc=0
abort  input  1  synchronous; returns to IDLE from any state, pc cleared
rom_addr  output  ADDR_W  ROM address, equal to pc
rom_data  input  DATA_W  ROM read data, valid one Mclk after rom_addr is sampled
instr  output  DATA_W  registered instruction presented to the SCU
run  output  1  registered one-cycle pulse: instr is valid, SCU may execute
done  input  1  SCU completion level, Pclk domain
busy  output  1  high in every state except IDLE
prog_done  output  1  one-cycle pulse after the LAST_ADDR instruction completes

Behaviour:
- Reset: state=IDLE, pc=0, instr=0, run=0, busy=0, prog_done=0, done-edge history=0.
- States: IDLE, FETCH, LOAD, WAIT, NEXT. Use a 3-bit encoding.
- IDLE: if start=1 and abort=0, go to FETCH. pc remains 0.
- FETCH: rom_addr=pc is presented for one cycle. Go to LOAD.
- LOAD:
  - instr<=rom_data and run<=1 at the same edge. Go to WAIT.
  - Latency: start sampled at edge k gives instr valid and run=1 from edge k+2.
- WAIT:
  - run<=0 at the first WAIT edge, so run is high for exactly one Mclk cycle.
  - Stay in WAIT until a rising edge of done is detected (done_s=1 and done_q=0), then go to NEXT.
  - A done level that is already high when WAIT is entered does not count; a new rising edge is required.
  - instr is held stable throughout WAIT.
- NEXT:
  - If pc==LAST_ADDR: pc<=0, prog_done<=1 for one cycle, go to IDLE.
  - Otherwise: pc<=pc+1 (ADDR_W-bit modulo), go to FETCH.
- Wrap-around: with LAST_ADDR=2^ADDR_W-1, pc returns to 0 with no overflow artefacts.
- abort has priority over every transition, including start in IDLE and a done edge in WAIT.
  - Next edge: state=IDLE, pc=0, run=0, prog_done=0.
  - instr keeps its last value.
- start held high in IDLE after prog_done restarts the program at the following edge.
- Resetn asserted mid-operation clears everything immediately (asynchronously), regardless of Mclk.
- busy is decoded from the state; it is 0 only in IDLE.

Optional Feature:
Macro IFS_DONE_SYNC_EN.
- Defined: done passes through a two-flop Mclk synchronizer, then the edge detector. Done-to-NEXT latency is 3 Mclk edges.
- Undefined: done feeds the edge detector directly (done_s=done). Done-to-NEXT latency is 1 edge. Only legal when Pclk and Mclk are the same clock.

Decomposition:
- Shared package ifs_pkg holds:
  - state enum/localparams: IDLE=0, FETCH=1, LOAD=2, WAIT=3, NEXT=4;
  - default ADDR_W, DATA_W, LAST_ADDR constants.
- One sub-module: sync_edge_det. It contains the optional 2-flop synchronizer and the rising-edge detector, with ports clk, rst_n, d, rise.

Test Plan:
1. Reset: Resetn=0 → state IDLE, rom_addr=0, instr=0, run=0, busy=0, prog_done=0; no change while start=0.
2. Single fetch: ROM[0]=16'hA5C3, start pulse at edge k → rom_addr=0, instr=16'hA5C3 with run=1 exactly at edge k+2, busy=1; instr held until done rises.
3. Full program:
   - ROM[i]=16'h1000+i; SCU model raises done 4 Pclk cycles after each run.
   - Expect 16 run pulses with instr 16'h1000..16'h100F in order.
   - Expect one prog_done pulse after the done for address 15, then pc=0 and busy=0.
4. Stale done: done already high when run issues → no advance until done falls and rises again.
5. Abort:
   - abort in WAIT at pc=6 → IDLE next edge, pc=0, run=0, no prog_done.
   - abort and start together in IDLE → stays IDLE.
6. Async reset mid-WAIT at pc=9, between Mclk edges → outputs cleared immediately; after release, start refetches from address 0. Run this with IFS_DONE_SYNC_EN defined, checking the done→NEXT latency is 3 edges, and again undefined, checking it is 1 edge.
